// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package reg_file_mp_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 3;
   localparam int DEF_NUM_RD = 2;
   localparam int NUM_WR     = 2;

   // Number of words addressed by an address of the given width.
   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/reg_file_cell.sv
// One register-file word: sync reset, two write enables, port 1 wins a collision.
module reg_file_cell
   import reg_file_mp_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we0,
   input  logic              we1,
   input  logic [DATA_W-1:0] d0,
   input  logic [DATA_W-1:0] d1,
   output logic [DATA_W-1:0] q
);

   // Word storage; port 1 is checked first so it overrides port 0.
   always_ff @(posedge clk) begin
      if (rst)      q <= '0;
      else if (we1) q <= d1;
      else if (we0) q <= d0;
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: DEPTH words, NUM_RD registered read ports, 2 write ports,
// optional write-to-read bypass and optional hardwired-zero register 0.
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_WR-1:0]          wr_en,
   input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
   input  logic [NUM_WR*DATA_W-1:0]   wr_data,
   input  logic [NUM_RD-1:0]          rd_en,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_valid
);

   localparam int DEPTH = depth_of(ADDR_W);

   logic [ADDR_W-1:0] wa0, wa1;
   logic [DATA_W-1:0] wd0, wd1;

   assign wa0 = wr_addr[0 +: ADDR_W];
   assign wa1 = wr_addr[ADDR_W +: ADDR_W];
   assign wd0 = wr_data[0 +: DATA_W];
   assign wd1 = wr_data[DATA_W +: DATA_W];

   logic [DEPTH-1:0][DATA_W-1:0] mem;

   // Word array; word 0 collapses to a constant when it is the zero register.
   for (genvar w = 0; w < DEPTH; w++) begin : g_word
      if (ZERO_REG != 0 && w == 0) begin : g_zero
         assign mem[w] = '0;
      end else begin : g_cell
         reg_file_cell #(.DATA_W(DATA_W)) u_cell (
            .clk (clk),
            .rst (rst),
            .we0 (wr_en[0] && (wa0 == ADDR_W'(w))),
            .we1 (wr_en[1] && (wa1 == ADDR_W'(w))),
            .d0  (wd0),
            .d1  (wd1),
            .q   (mem[w])
         );
      end
   end

   logic [NUM_RD-1:0][DATA_W-1:0] rd_val;

   // Per-port read mux with optional bypass of this cycle's winning write.
   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = rd_addr[r*ADDR_W +: ADDR_W];

      always_comb begin
         rd_val[r] = mem[ra];
         if (BYPASS != 0) begin
            if (wr_en[0] && wa0 == ra) rd_val[r] = wd0;
            if (wr_en[1] && wa1 == ra) rd_val[r] = wd1;
         end
         // Zero register stays zero even when a bypassed write targets it.
         if (ZERO_REG != 0 && ra == '0) rd_val[r] = '0;
      end
   end

   // Output registers: disabled ports hold data and drop valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= '0;
      end else begin
         for (int r = 0; r < NUM_RD; r++) begin
            rd_valid[r] <= rd_en[r];
            if (rd_en[r]) rd_data[r*DATA_W +: DATA_W] <= rd_val[r];
         end
      end
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a default instance (bypass on), a no-bypass
// instance and a zero-register instance share the same stimulus.
module tb_reg_file_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  wr_en;
   logic [5:0]  wr_addr;
   logic [31:0] wr_data;
   logic [1:0]  rd_en;
   logic [5:0]  rd_addr;
   logic [31:0] rd_data_a, rd_data_b, rd_data_c;
   logic [1:0]  rd_valid_a, rd_valid_b, rd_valid_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_file_mp u_dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a));

   reg_file_mp #(.BYPASS(0)) u_nb (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b));

   reg_file_mp #(.ZERO_REG(1)) u_zr (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_valid(rd_valid_c));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 2'b00; rd_en = 2'b00;
   endtask

   task automatic test_reset();
      rst = 1'b1; idle(); wr_addr = '0; wr_data = '0; rd_addr = '0;
      step();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wr_en = 2'b01; wr_addr = {3'd0, 3'(i)}; wr_data = {16'h0, 16'hFFFF};
         step();
      end
      idle(); rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({rd_valid_a, rd_data_a} !== 34'h0) begin
         errors++; $display("FAIL reset_out got %h want 0", {rd_valid_a, rd_data_a});
      end
      for (int i = 0; i < 8; i++) begin
         rd_en = 2'b11; rd_addr = {3'(7 - i), 3'(i)};
         step();
         checks++;
         if ({rd_valid_a, rd_data_a} !== {2'b11, 32'h0}) begin
            errors++; $display("FAIL reset_read addr %0d got %h want 3_00000000", i, {rd_valid_a, rd_data_a});
         end
         checks++;
         if ({rd_valid_b, rd_data_b} !== {2'b11, 32'h0}) begin
            errors++; $display("FAIL reset_read_nb addr %0d got %h want 3_00000000", i, {rd_valid_b, rd_data_b});
         end
      end
      idle();
   endtask

   task automatic test_basic();
      wr_en = 2'b01; wr_addr = {3'd0, 3'd3}; wr_data = {16'h0, 16'h1234};
      step();
      idle(); rd_en = 2'b01; rd_addr = {3'd0, 3'd3};
      step();
      idle();
      checks++;
      if ({rd_valid_a[0], rd_data_a[15:0]} !== {1'b1, 16'h1234}) begin
         errors++; $display("FAIL basic got %h want 1_1234", {rd_valid_a[0], rd_data_a[15:0]});
      end
      checks++;
      if ({rd_valid_b[0], rd_data_b[15:0]} !== {1'b1, 16'h1234}) begin
         errors++; $display("FAIL basic_nb got %h want 1_1234", {rd_valid_b[0], rd_data_b[15:0]});
      end
   endtask

   task automatic test_bypass();
      wr_en = 2'b01; wr_addr = {3'd0, 3'd5}; wr_data = {16'h0, 16'hABCD};
      rd_en = 2'b10; rd_addr = {3'd5, 3'd0};
      step();
      idle();
      checks++;
      if ({rd_valid_a[1], rd_data_a[31:16]} !== {1'b1, 16'hABCD}) begin
         errors++; $display("FAIL bypass got %h want 1_abcd", {rd_valid_a[1], rd_data_a[31:16]});
      end
      checks++;
      if ({rd_valid_b[1], rd_data_b[31:16]} !== {1'b1, 16'h0000}) begin
         errors++; $display("FAIL bypass_off got %h want 1_0000", {rd_valid_b[1], rd_data_b[31:16]});
      end
      rd_en = 2'b10; rd_addr = {3'd5, 3'd0};
      step();
      idle();
      checks++;
      if (rd_data_b[31:16] !== 16'hABCD) begin
         errors++; $display("FAIL bypass_off_later got %h want abcd", rd_data_b[31:16]);
      end
   endtask

   task automatic test_collision();
      wr_en = 2'b11; wr_addr = {3'd2, 3'd2}; wr_data = {16'h0002, 16'h0001};
      step();
      idle(); rd_en = 2'b01; rd_addr = {3'd0, 3'd2};
      step();
      idle();
      checks++;
      if (rd_data_a[15:0] !== 16'h0002) begin
         errors++; $display("FAIL collision got %h want 0002", rd_data_a[15:0]);
      end
      wr_en = 2'b11; wr_addr = {3'd2, 3'd2}; wr_data = {16'h0004, 16'h0003};
      rd_en = 2'b11; rd_addr = {3'd2, 3'd2};
      step();
      idle();
      checks++;
      if (rd_data_a !== {16'h0004, 16'h0004}) begin
         errors++; $display("FAIL collision_bypass got %h want 00040004", rd_data_a);
      end
      checks++;
      if (rd_data_b !== {16'h0002, 16'h0002}) begin
         errors++; $display("FAIL collision_nobypass got %h want 00020002", rd_data_b);
      end
   endtask

   task automatic test_zero_reg();
      wr_en = 2'b10; wr_addr = {3'd0, 3'd7}; wr_data = {16'h5555, 16'h0};
      rd_en = 2'b01; rd_addr = {3'd0, 3'd0};
      step();
      idle();
      checks++;
      if ({rd_valid_c[0], rd_data_c[15:0]} !== {1'b1, 16'h0000}) begin
         errors++; $display("FAIL zero_bypass got %h want 1_0000", {rd_valid_c[0], rd_data_c[15:0]});
      end
      checks++;
      if (rd_data_a[15:0] !== 16'h5555) begin
         errors++; $display("FAIL nonzero_bypass got %h want 5555", rd_data_a[15:0]);
      end
      rd_en = 2'b11; rd_addr = {3'd0, 3'd0};
      step();
      idle();
      checks++;
      if (rd_data_c !== 32'h0) begin
         errors++; $display("FAIL zero_later got %h want 0", rd_data_c);
      end
      checks++;
      if (rd_data_a !== {16'h5555, 16'h5555}) begin
         errors++; $display("FAIL nonzero_later got %h want 55555555", rd_data_a);
      end
   endtask

   task automatic test_rd_disable_rst();
      rd_en = 2'b01; rd_addr = {3'd0, 3'd3};
      step();
      idle();
      step();
      checks++;
      if ({rd_valid_a, rd_data_a[15:0]} !== {2'b00, 16'h1234}) begin
         errors++; $display("FAIL rd_hold got %h want 0_1234", {rd_valid_a, rd_data_a[15:0]});
      end
      rst = 1'b1;
      wr_en = 2'b11; wr_addr = {3'd4, 3'd6}; wr_data = {16'hBEEF, 16'hCAFE};
      rd_en = 2'b11; rd_addr = {3'd3, 3'd5};
      step();
      rst = 1'b0; idle();
      checks++;
      if ({rd_valid_a, rd_data_a} !== 34'h0) begin
         errors++; $display("FAIL rst_priority_out got %h want 0", {rd_valid_a, rd_data_a});
      end
      rd_en = 2'b11; rd_addr = {3'd4, 3'd6};
      step();
      idle();
      checks++;
      if ({rd_valid_a, rd_data_a} !== {2'b11, 32'h0}) begin
         errors++; $display("FAIL rst_priority_mem got %h want 3_00000000", {rd_valid_a, rd_data_a});
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp;
      for (int i = 0; i < 6; i++) begin
         wr_en = 2'b01; wr_addr = {3'd0, 3'(i + 1)}; wr_data = {16'h0, 16'(16'h1100 + i)};
         rd_en = (i > 0) ? 2'b01 : 2'b00; rd_addr = {3'd0, 3'(i)};
         step();
         if (i > 0) begin
            exp = 16'h1100 + 16'(i - 1);
            checks++;
            if (rd_data_b[15:0] !== exp) begin
               errors++; $display("FAIL b2b addr %0d got %h want %h", i, rd_data_b[15:0], exp);
            end
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bypass();
      test_collision();
      test_zero_reg();
      test_rd_disable_rst();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
